// File: rtl/credit_register.sv
// Credit store for a vending controller: coin accumulate, load, purchase,
// and a refund handshake that holds the full balance until acknowledged.
module credit_register #(
  parameter int WIDTH      = 9,
  parameter int MAX_CREDIT = 500
) (
  input  logic             Clk,
  input  logic             Clr,
  input  logic             Load,
  input  logic [WIDTH-1:0] D,
  input  logic             Add,
  input  logic [WIDTH-1:0] Coin,
  input  logic             Buy,
  input  logic [WIDTH-1:0] Price,
  input  logic             Cancel,
  input  logic             Ret_ack,
  output logic [WIDTH-1:0] Q,
  output logic             Busy,
  output logic             Vend_ok,
  output logic             Nsf,
  output logic             Sat,
  output logic             Ret_req,
  output logic [WIDTH-1:0] Ret_amt
);

  localparam logic [WIDTH:0]   MAX_W = (WIDTH+1)'(MAX_CREDIT);
  localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MAX_CREDIT);

  typedef enum logic {IDLE, RETURN} state_t;

  state_t         state;
  logic [WIDTH:0] sum;
  logic [WIDTH:0] dw;

  // One extra bit so Q + Coin can never wrap before the clip.
  always_comb begin
    sum = {1'b0, Q} + {1'b0, Coin};
    dw  = {1'b0, D};
  end

  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr) begin
      state   <= IDLE;
      Q       <= '0;
      Ret_amt <= '0;
      Ret_req <= 1'b0;
      Busy    <= 1'b0;
      Vend_ok <= 1'b0;
      Nsf     <= 1'b0;
      Sat     <= 1'b0;
    end else begin
      Vend_ok <= 1'b0;
      Nsf     <= 1'b0;
      Sat     <= 1'b0;
      unique case (state)
        IDLE: begin
          if (Cancel) begin
            if (Q != '0) begin
              Ret_amt <= Q;
              Q       <= '0;
              Ret_req <= 1'b1;
              Busy    <= 1'b1;
              state   <= RETURN;
            end
          end else if (Buy) begin
            if (Q >= Price) begin
              Q       <= Q - Price;
              Vend_ok <= 1'b1;
            end else begin
              Nsf <= 1'b1;
            end
          end else if (Load) begin
            if (dw > MAX_W) begin
              Q   <= MAX_Q;
              Sat <= 1'b1;
            end else begin
              Q <= D;
            end
          end else if (Add) begin
            if (sum > MAX_W) begin
              Q   <= MAX_Q;
              Sat <= 1'b1;
            end else begin
              Q <= sum[WIDTH-1:0];
            end
          end
        end
        RETURN: begin
          if (Ret_ack) begin
            Ret_req <= 1'b0;
            Ret_amt <= '0;
            Busy    <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_credit_register.sv
// Directed bench for credit_register: accumulate, saturation, purchase,
// priority, refund handshake and asynchronous clear.
module tb_credit_register;

  logic       Clk = 1'b0;
  logic       Clr, Load, Add, Buy, Cancel, Ret_ack;
  logic [8:0] D, Coin, Price;
  logic [8:0] Q, Ret_amt;
  logic       Busy, Vend_ok, Nsf, Sat, Ret_req;

  int checks = 0;
  int errors = 0;

  credit_register #(.WIDTH(9), .MAX_CREDIT(500)) dut (
    .Clk(Clk), .Clr(Clr), .Load(Load), .D(D),
    .Add(Add), .Coin(Coin), .Buy(Buy), .Price(Price),
    .Cancel(Cancel), .Ret_ack(Ret_ack), .Q(Q), .Busy(Busy),
    .Vend_ok(Vend_ok), .Nsf(Nsf), .Sat(Sat),
    .Ret_req(Ret_req), .Ret_amt(Ret_amt)
  );

  always #5 Clk = ~Clk;

  task automatic cycle();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle_cmds();
    Load = 0; Add = 0; Buy = 0; Cancel = 0; Ret_ack = 0;
    D = 0; Coin = 0; Price = 0;
  endtask

  task automatic test_reset();
    Clr = 1; idle_cmds();
    #2;
    checks++; if (Q !== 9'd0) begin errors++; $display("FAIL rst_q got=%0d exp=0", Q); end
    checks++; if ({Busy, Vend_ok, Nsf, Sat, Ret_req} !== 5'b0) begin errors++; $display("FAIL rst_flags got=%b exp=00000", {Busy, Vend_ok, Nsf, Sat, Ret_req}); end
    checks++; if (Ret_amt !== 9'd0) begin errors++; $display("FAIL rst_amt got=%0d exp=0", Ret_amt); end
    cycle();
    Clr = 0;
    cycle();
  endtask

  task automatic test_accumulate();
    Add = 1; Coin = 100; cycle();
    checks++; if (Q !== 9'd100 || Sat !== 1'b0) begin errors++; $display("FAIL acc1 got=%0d sat=%b exp=100 sat=0", Q, Sat); end
    Coin = 25; cycle();
    checks++; if (Q !== 9'd125 || Sat !== 1'b0) begin errors++; $display("FAIL acc2 got=%0d sat=%b exp=125 sat=0", Q, Sat); end
    Coin = 200; cycle();
    checks++; if (Q !== 9'd325 || Sat !== 1'b0) begin errors++; $display("FAIL acc3 got=%0d sat=%b exp=325 sat=0", Q, Sat); end
    idle_cmds();
  endtask

  task automatic test_buy();
    Buy = 1; Price = 150; cycle();
    checks++; if (Q !== 9'd175 || Vend_ok !== 1'b1 || Nsf !== 1'b0) begin errors++; $display("FAIL buy_ok got=%0d v=%b n=%b exp=175 v=1 n=0", Q, Vend_ok, Nsf); end
    Buy = 0; cycle();
    checks++; if (Vend_ok !== 1'b0) begin errors++; $display("FAIL vend_pulse got=%b exp=0", Vend_ok); end
    Buy = 1; Price = 200; cycle();
    checks++; if (Q !== 9'd175 || Nsf !== 1'b1 || Vend_ok !== 1'b0) begin errors++; $display("FAIL buy_nsf got=%0d n=%b v=%b exp=175 n=1 v=0", Q, Nsf, Vend_ok); end
    Price = 0; cycle();
    checks++; if (Q !== 9'd175 || Vend_ok !== 1'b1 || Nsf !== 1'b0) begin errors++; $display("FAIL buy_zero got=%0d v=%b n=%b exp=175 v=1 n=0", Q, Vend_ok, Nsf); end
    Price = 175; cycle();
    checks++; if (Q !== 9'd0 || Vend_ok !== 1'b1) begin errors++; $display("FAIL buy_exact got=%0d v=%b exp=0 v=1", Q, Vend_ok); end
    idle_cmds();
    Load = 1; D = 175; cycle();
    checks++; if (Q !== 9'd175 || Sat !== 1'b0) begin errors++; $display("FAIL load175 got=%0d sat=%b exp=175 sat=0", Q, Sat); end
    idle_cmds();
  endtask

  task automatic test_priority();
    Cancel = 1; Buy = 1; Price = 10; Add = 1; Coin = 5; cycle();
    idle_cmds();
    checks++; if (Busy !== 1'b1 || Ret_req !== 1'b1) begin errors++; $display("FAIL pri_state busy=%b req=%b exp=1 1", Busy, Ret_req); end
    checks++; if (Ret_amt !== 9'd175 || Q !== 9'd0) begin errors++; $display("FAIL pri_amt amt=%0d q=%0d exp=175 0", Ret_amt, Q); end
    checks++; if (Vend_ok !== 1'b0 || Sat !== 1'b0 || Nsf !== 1'b0) begin errors++; $display("FAIL pri_pulse v=%b s=%b n=%b exp=000", Vend_ok, Sat, Nsf); end
  endtask

  task automatic test_handshake();
    Add = 1; Coin = 50; Buy = 1; Load = 1; D = 300;
    for (int i = 0; i < 5; i++) begin
      cycle();
      checks++;
      if (Ret_req !== 1'b1 || Ret_amt !== 9'd175 || Q !== 9'd0 || Busy !== 1'b1 || Sat !== 1'b0 || Vend_ok !== 1'b0) begin
        errors++;
        $display("FAIL hold%0d req=%b amt=%0d q=%0d busy=%b sat=%b v=%b exp=1 175 0 1 0 0", i, Ret_req, Ret_amt, Q, Busy, Sat, Vend_ok);
      end
    end
    idle_cmds();
    Ret_ack = 1; cycle();
    Ret_ack = 0;
    checks++; if (Ret_req !== 1'b0 || Busy !== 1'b0 || Ret_amt !== 9'd0) begin errors++; $display("FAIL ack req=%b busy=%b amt=%0d exp=0 0 0", Ret_req, Busy, Ret_amt); end
    Add = 1; Coin = 7; cycle();
    idle_cmds();
    checks++; if (Q !== 9'd7) begin errors++; $display("FAIL post_ack_add got=%0d exp=7", Q); end
  endtask

  task automatic test_idle_noops();
    Ret_ack = 1; cycle();
    checks++; if (Q !== 9'd7 || Busy !== 1'b0 || Ret_req !== 1'b0) begin errors++; $display("FAIL ack_idle q=%0d busy=%b req=%b exp=7 0 0", Q, Busy, Ret_req); end
    idle_cmds();
    Buy = 1; Price = 7; cycle();
    idle_cmds();
    Cancel = 1; Add = 1; Coin = 3; cycle();
    idle_cmds();
    checks++; if (Q !== 9'd0 || Busy !== 1'b0 || Ret_req !== 1'b0 || Sat !== 1'b0) begin errors++; $display("FAIL cancel_zero q=%0d busy=%b req=%b sat=%b exp=0 0 0 0", Q, Busy, Ret_req, Sat); end
  endtask

  task automatic test_saturation();
    Load = 1; D = 450; cycle();
    idle_cmds();
    checks++; if (Q !== 9'd450 || Sat !== 1'b0) begin errors++; $display("FAIL load450 got=%0d sat=%b exp=450 0", Q, Sat); end
    Add = 1; Coin = 100; cycle();
    idle_cmds();
    checks++; if (Q !== 9'd500 || Sat !== 1'b1) begin errors++; $display("FAIL add_sat got=%0d sat=%b exp=500 1", Q, Sat); end
    cycle();
    checks++; if (Sat !== 1'b0) begin errors++; $display("FAIL sat_pulse got=%b exp=0", Sat); end
    Add = 1; Coin = 1; cycle();
    idle_cmds();
    checks++; if (Q !== 9'd500 || Sat !== 1'b1) begin errors++; $display("FAIL add_at_max got=%0d sat=%b exp=500 1", Q, Sat); end
    Load = 1; D = 511; cycle();
    idle_cmds();
    checks++; if (Q !== 9'd500 || Sat !== 1'b1) begin errors++; $display("FAIL load511 got=%0d sat=%b exp=500 1", Q, Sat); end
    Load = 1; D = 500; cycle();
    idle_cmds();
    checks++; if (Q !== 9'd500 || Sat !== 1'b0) begin errors++; $display("FAIL load500 got=%0d sat=%b exp=500 0", Q, Sat); end
    Load = 1; D = 400; cycle();
    Load = 0; Add = 1; Coin = 200; cycle();
    idle_cmds();
    checks++; if (Q !== 9'd500 || Sat !== 1'b1) begin errors++; $display("FAIL add_wrap got=%0d sat=%b exp=500 1", Q, Sat); end
    Load = 1; D = 300; cycle();
    Load = 0; Add = 1; Coin = 200; cycle();
    idle_cmds();
    checks++; if (Q !== 9'd500 || Sat !== 1'b0) begin errors++; $display("FAIL add_exact got=%0d sat=%b exp=500 0", Q, Sat); end
    Load = 1; Add = 1; D = 20; Coin = 5; cycle();
    idle_cmds();
    checks++; if (Q !== 9'd20) begin errors++; $display("FAIL load_over_add got=%0d exp=20", Q); end
  endtask

  task automatic test_async_clear();
    Load = 1; D = 175; cycle();
    idle_cmds();
    Cancel = 1; cycle();
    idle_cmds();
    checks++; if (Ret_amt !== 9'd175 || Busy !== 1'b1) begin errors++; $display("FAIL clr_setup amt=%0d busy=%b exp=175 1", Ret_amt, Busy); end
    #2 Clr = 1;
    #1;
    checks++; if ({Busy, Vend_ok, Nsf, Sat, Ret_req} !== 5'b0 || Q !== 9'd0 || Ret_amt !== 9'd0) begin errors++; $display("FAIL clr_async flags=%b q=%0d amt=%0d exp=00000 0 0", {Busy, Vend_ok, Nsf, Sat, Ret_req}, Q, Ret_amt); end
    #1 Clr = 0;
    Add = 1; Coin = 10; cycle();
    idle_cmds();
    checks++; if (Q !== 9'd10 || Busy !== 1'b0 || Ret_req !== 1'b0) begin errors++; $display("FAIL clr_after q=%0d busy=%b req=%b exp=10 0 0", Q, Busy, Ret_req); end
  endtask

  initial begin
    test_reset();
    test_accumulate();
    test_buy();
    test_priority();
    test_handshake();
    test_idle_noops();
    test_saturation();
    test_async_clear();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/credit_register.md
CREDIT_REGISTER -- requirements
Module: credit_register

Interface
REQ-001 The block SHALL have parameter WIDTH, default 9, giving the bit width of every credit, coin, price and load value.
REQ-002 The block SHALL have parameter MAX_CREDIT, default 500, giving the saturation ceiling for stored credit; MAX_CREDIT SHALL be less than 2**WIDTH.
REQ-003 The block SHALL have port Clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-004 The block SHALL have port Clr, input, 1 bit: reset, asynchronous and active-high.
REQ-005 The block SHALL have port Load, input, 1 bit: load request for the credit value.
REQ-006 The block SHALL have port D, input, WIDTH bits: the value to load.
REQ-007 The block SHALL have port Add, input, 1 bit: coin accumulate request.
REQ-008 The block SHALL have port Coin, input, WIDTH bits: the coin value to add.
REQ-009 The block SHALL have port Buy, input, 1 bit: purchase request.
REQ-010 The block SHALL have port Price, input, WIDTH bits: the purchase price.
REQ-011 The block SHALL have port Cancel, input, 1 bit: refund request for all stored credit.
REQ-012 The block SHALL have port Ret_ack, input, 1 bit: the refund handshake acknowledge.
REQ-013 The block SHALL have port Q, output, WIDTH bits: the stored credit.
REQ-014 The block SHALL have port Busy, output, 1 bit: high while in the RETURN state.
REQ-015 The block SHALL have port Vend_ok, output, 1 bit: a one-cycle pulse on a successful purchase.
REQ-016 The block SHALL have port Nsf, output, 1 bit: a one-cycle pulse on a purchase with insufficient funds.
REQ-017 The block SHALL have port Sat, output, 1 bit: a one-cycle pulse when a load or add was clipped to MAX_CREDIT.
REQ-018 The block SHALL have port Ret_req, output, 1 bit: the refund request, held until acknowledged.
REQ-019 The block SHALL have port Ret_amt, output, WIDTH bits: the refund amount, valid while Ret_req is high.

Function
REQ-020 The FSM SHALL have exactly two states: IDLE and RETURN.
REQ-021 All outputs SHALL be registered, and every command SHALL take effect on the first rising Clk edge after it is sampled (1-cycle latency).
REQ-022 In IDLE, the fixed command priority SHALL be Cancel > Buy > Load > Add; only the highest-priority asserted command acts and the others are dropped.
REQ-023 Cancel in IDLE with Q != 0 SHALL set Ret_amt = Q, Q = 0, Ret_req = 1, Busy = 1 and move to RETURN.
REQ-024 Cancel in IDLE with Q == 0 SHALL be a no-op: state stays IDLE and no pulses occur.
REQ-025 Buy with Q >= Price (unsigned) SHALL set Q = Q - Price and pulse Vend_ok for one cycle; state stays IDLE, so remaining credit allows further purchases.
REQ-026 Buy with Price == 0 SHALL count as a success: Q unchanged, Vend_ok pulses.
REQ-027 Buy with Q < Price SHALL leave Q unchanged and pulse Nsf for one cycle.
REQ-028 Load SHALL set Q = min(D, MAX_CREDIT) and pulse Sat if D > MAX_CREDIT.
REQ-029 Add SHALL set Q = min(Q + Coin, MAX_CREDIT), with the sum computed at WIDTH+1 bits so it never wraps, and pulse Sat if the sum > MAX_CREDIT.
REQ-030 Add with Q already at MAX_CREDIT and Coin > 0 SHALL leave Q unchanged and pulse Sat.
REQ-031 In RETURN, Ret_req and Ret_amt SHALL hold stable until a cycle in which Ret_ack = 1 is sampled.
REQ-032 On that Ret_ack cycle, the next edge SHALL clear Ret_req, Ret_amt and Busy and return the FSM to IDLE.
REQ-033 In RETURN, Load, Add, Buy and Cancel SHALL be ignored with no pulses, and Q SHALL stay 0.
REQ-034 Ret_ack sampled in IDLE SHALL have no effect.
REQ-035 Vend_ok, Nsf and Sat SHALL each be high for exactly one cycle per triggering command and low otherwise; at most one of the three is high in any cycle.

Reset
REQ-036 While Clr is high, the block SHALL immediately (without waiting for Clk) force Q = 0, Ret_amt = 0, Ret_req = 0, Busy = 0, Vend_ok = 0, Nsf = 0, Sat = 0 and state = IDLE.
REQ-037 Clr asserted mid-RETURN SHALL abandon the refund: the pending Ret_amt is lost and Ret_req drops without a handshake.
REQ-038 After Clr deasserts, the first command SHALL be honoured on the next rising Clk edge.

Verification
REQ-039 The bench SHALL cover accumulate: Add 100, Add 25, Add 200 -> Q = 100, 125, 325, Sat never asserted.
REQ-040 The bench SHALL cover saturation: Q = 450, Add 100 -> Q = 500, Sat pulses one cycle; Load 511 -> Q = 500, Sat pulses.
REQ-041 The bench SHALL cover purchases: Q = 325, Buy Price 150 -> Q = 175, Vend_ok pulses; then Buy Price 200 -> Q = 175, Nsf pulses.
REQ-042 The bench SHALL cover priority: Cancel, Buy and Add asserted together with Q = 175 -> RETURN, Ret_amt = 175, Q = 0, no Vend_ok, no Sat.
REQ-043 The bench SHALL cover the refund handshake: hold Ret_ack = 0 for 5 cycles while driving Add 50 -> Ret_req/Ret_amt = 175 stable, Q = 0, Busy = 1; Ret_ack = 1 -> next edge IDLE, Ret_req = 0, Busy = 0.
REQ-044 The bench SHALL cover asynchronous reset: assert Clr between clock edges during RETURN with Ret_amt = 175 -> all outputs 0 before the next edge; release, then Add 10 -> Q = 10.
